// File: rtl/pi_code_ctrl_if.sv
// pi_code_ctrl_if: bundle between the phase detector / loop control (master)
// and the phase-code controller (slave).
//   enable, hold       loop enable and loop freeze
//   vote_valid, early, late, vote_ready   early/late vote handshake
//   code, code_update, lock               phase code to the mixer and status
interface pi_code_ctrl_if;
  logic       enable;
  logic       hold;
  logic       vote_valid;
  logic       early;
  logic       late;
  logic       vote_ready;
  logic [9:0] code;
  logic       code_update;
  logic       lock;

  // Detector / loop control side
  modport master (
    output enable, hold, vote_valid, early, late,
    input  vote_ready, code, code_update, lock
  );

  // Phase-code controller side
  modport slave (
    input  enable, hold, vote_valid, early, late,
    output vote_ready, code, code_update, lock
  );
endinterface

// File: rtl/pi_code_ctrl.sv
// pi_code_ctrl: digital phase controller for the CDR phase mixer.
// Filters bang-bang early/late votes over VOTE_LEN-vote windows and steps a
// 10-bit phase code (code[9:8] quadrant, code[7:0] weight) modulo 1024.
// Optional integral path built when PI_CTRL_FREQ_PATH_EN is defined.
// Ports:
//   clk_i      rising-edge clock
//   rst_i      asynchronous active-high reset
//   bus        pi_code_ctrl_if.slave: enable/hold/vote inputs,
//              vote_ready/code/code_update/lock outputs (all registered)
module pi_code_ctrl #(
  parameter int unsigned VOTE_LEN  = 8,
  parameter int unsigned KP        = 4,
  parameter logic [9:0]  INIT_CODE = 10'd0,
  parameter int unsigned FREQ_W    = 12,
  parameter int unsigned KI_SHIFT  = 6
) (
  input  logic          clk_i,
  input  logic          rst_i,
  pi_code_ctrl_if.slave bus
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned SUM_W  = 9;
  localparam int unsigned CODE_W = 10;
  localparam int unsigned STEP_W = 32;
  localparam int unsigned ALT_W  = 3;

  localparam logic signed [STEP_W-1:0] KP_S      = STEP_W'(KP);
  localparam logic signed [STEP_W-1:0] STEP_MAX  = 32'sd127;
  localparam logic signed [STEP_W-1:0] STEP_MIN  = -32'sd127;
  localparam logic [ALT_W-1:0]         ALT_LOCK  = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_APPLY = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DN   = 2'd2
  } dir_e;

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic signed [SUM_W-1:0]   sum_q, sum_d;
  logic [CODE_W-1:0]         code_q, code_d;
  logic                      upd_q, upd_d;
  logic                      ready_q, ready_d;
  logic                      lock_q, lock_d;
  dir_e                      last_q, last_d;
  logic [ALT_W-1:0]          alt_q, alt_d;

  logic                      run;
  logic                      accept;
  logic signed [SUM_W-1:0]   vote;
  dir_e                      dir;
  logic signed [STEP_W-1:0]  step_raw;
  logic signed [STEP_W-1:0]  step;
  logic [ALT_W-1:0]          alt_inc;

`ifdef PI_CTRL_FREQ_PATH_EN
  localparam logic signed [FREQ_W-1:0] INTEG_MAX = {1'b0, {(FREQ_W-1){1'b1}}};
  localparam logic signed [FREQ_W-1:0] INTEG_MIN = {1'b1, {(FREQ_W-1){1'b0}}};
  logic signed [FREQ_W-1:0]  integ_q, integ_d;
`else
  // Integrator sizing only matters when the frequency path is built
  logic unused_cfg;
  assign unused_cfg = ^{FREQ_W, KI_SHIFT};
`endif

  assign run    = bus.enable && !bus.hold;
  assign accept = bus.vote_valid && ready_q;

  // Vote weight: +1 early only, -1 late only, 0 for both/neither
  always_comb begin
    vote = '0;
    case ({bus.early, bus.late})
      2'b10:   vote = 9'sd1;
      2'b01:   vote = -9'sd1;
      default: vote = '0;
    endcase
  end

  // Window decision from the accumulated sum
  always_comb begin
    dir = DIR_NONE;
    if (sum_q > 9'sd0) begin
      dir = DIR_UP;
    end else if (sum_q < 9'sd0) begin
      dir = DIR_DN;
    end
  end

  // Step = +/-KP (+ scaled integrator), clamped to +/-127
  always_comb begin
    step_raw = '0;
    step     = '0;
    if (dir == DIR_UP) begin
      step_raw = KP_S;
    end else if (dir == DIR_DN) begin
      step_raw = -KP_S;
    end
`ifdef PI_CTRL_FREQ_PATH_EN
    if (dir != DIR_NONE) begin
      step_raw = step_raw + (STEP_W'(integ_q) >>> KI_SHIFT);
    end
`endif
    if (step_raw > STEP_MAX) begin
      step = STEP_MAX;
    end else if (step_raw < STEP_MIN) begin
      step = STEP_MIN;
    end else begin
      step = step_raw;
    end
  end

  assign alt_inc = (alt_q == ALT_LOCK) ? ALT_LOCK : alt_q + 3'd1;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; loss of enable or hold wins from every state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (!run) begin
          state_d = S_IDLE;
        end else if (accept && (cnt_q == CNT_W'(VOTE_LEN - 1))) begin
          state_d = S_APPLY;
        end
      end
      S_APPLY: begin
        state_d = run ? S_ACCUM : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    upd_d   = 1'b0;
    lock_d  = lock_q;
    last_d  = last_q;
    alt_d   = alt_q;
`ifdef PI_CTRL_FREQ_PATH_EN
    integ_d = integ_q;
`endif
    ready_d = (state_d == S_ACCUM);

    case (state_q)
      S_ACCUM: begin
        if (accept) begin
          sum_d = sum_q + vote;
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_APPLY: begin
        sum_d = '0;
        cnt_d = '0;
        // An APPLY abandoned by hold/disable leaves code, integrator and lock alone
        if (run) begin
          if ((dir != DIR_NONE) && (step != '0)) begin
            code_d = code_q + step[CODE_W-1:0];
            upd_d  = 1'b1;
          end
          // Two consecutive same-direction decisions break lock
          if ((dir != DIR_NONE) && (dir == last_q)) begin
            alt_d  = 3'd1;
            lock_d = 1'b0;
          end else begin
            alt_d  = alt_inc;
            lock_d = (alt_inc == ALT_LOCK);
          end
          last_d = dir;
`ifdef PI_CTRL_FREQ_PATH_EN
          if ((dir == DIR_UP) && (integ_q != INTEG_MAX)) begin
            integ_d = integ_q + FREQ_W'(1);
          end else if ((dir == DIR_DN) && (integ_q != INTEG_MIN)) begin
            integ_d = integ_q - FREQ_W'(1);
          end
`endif
        end
      end
      default: ;
    endcase

    // Entering or staying in IDLE discards the window and the lock history
    if (state_d == S_IDLE) begin
      sum_d  = '0;
      cnt_d  = '0;
      lock_d = 1'b0;
      last_d = DIR_NONE;
      alt_d  = '0;
    end
  end

  // Datapath registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sum_q   <= '0;
      cnt_q   <= '0;
      code_q  <= INIT_CODE;
      upd_q   <= 1'b0;
      ready_q <= 1'b0;
      lock_q  <= 1'b0;
      last_q  <= DIR_NONE;
      alt_q   <= '0;
`ifdef PI_CTRL_FREQ_PATH_EN
      integ_q <= '0;
`endif
    end else begin
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      upd_q   <= upd_d;
      ready_q <= ready_d;
      lock_q  <= lock_d;
      last_q  <= last_d;
      alt_q   <= alt_d;
`ifdef PI_CTRL_FREQ_PATH_EN
      integ_q <= integ_d;
`endif
    end
  end

  assign bus.vote_ready  = ready_q;
  assign bus.code        = code_q;
  assign bus.code_update = upd_q;
  assign bus.lock        = lock_q;

endmodule

// File: tb/tb_pi_code_ctrl.sv
// tb_pi_code_ctrl: directed scoreboard bench for pi_code_ctrl.
// Expected {code, lock} is queued when a window is issued; a monitor pops
// and compares on every code_update pulse.
module tb_pi_code_ctrl;

  localparam logic [9:0] INIT = 10'd1022;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pi_code_ctrl_if bus ();

  pi_code_ctrl #(
    .VOTE_LEN (8),
    .KP       (4),
    .INIT_CODE(INIT),
    .FREQ_W   (12),
    .KI_SHIFT (6)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  typedef struct packed {
    logic [9:0] code;
    logic       lock;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor: every code_update must match the oldest queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.code_update === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_update actual=code %0d required=no update", bus.code);
      end else begin
        e = exp_q.pop_front();
        check("mon_code", int'(bus.code), int'(e.code));
        check("mon_lock", int'(bus.lock), int'(e.lock));
      end
    end
  end

  // Offer one vote and return just after the edge that accepts it
  task automatic vote(input logic e, input logic l);
    int t;
    t = 0;
    @(negedge clk);
    bus.vote_valid = 1'b1;
    bus.early      = e;
    bus.late       = l;
    while (bus.vote_ready !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (bus.vote_ready !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL vote_timeout actual=ready %0b required=1", bus.vote_ready);
    end
    @(posedge clk);
    #1;
    bus.vote_valid = 1'b0;
    bus.early      = 1'b0;
    bus.late       = 1'b0;
  endtask

  // One 8-vote window: ne early-only, nl late-only, nb both, rest neither
  task automatic window(input string name, input int ne, input int nl, input int nb,
                        input bit upd, input logic [9:0] ec, input logic el);
    for (int i = 0; i < 8; i++) begin
      if (i == 7 && upd) exp_q.push_back('{code: ec, lock: el});
      if (i < ne)                vote(1'b1, 1'b0);
      else if (i < ne + nl)      vote(1'b0, 1'b1);
      else if (i < ne + nl + nb) vote(1'b1, 1'b1);
      else                       vote(1'b0, 1'b0);
    end
    @(negedge clk);
    check({name, "_apply_ready"}, int'(bus.vote_ready), 0);
    check({name, "_apply_upd"}, int'(bus.code_update), 0);
    @(negedge clk);
    check({name, "_code"}, int'(bus.code), int'(ec));
    check({name, "_lock"}, int'(bus.lock), int'(el));
    check({name, "_ready_back"}, int'(bus.vote_ready), 1);
    check({name, "_upd"}, int'(bus.code_update), int'(upd));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] mc;
    int         integ;
    int         st;

    bus.enable     = 1'b0;
    bus.hold       = 1'b0;
    bus.vote_valid = 1'b0;
    bus.early      = 1'b0;
    bus.late       = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_code", int'(bus.code), int'(INIT));
    check("rst_upd", int'(bus.code_update), 0);
    check("rst_ready", int'(bus.vote_ready), 0);
    check("rst_lock", int'(bus.lock), 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", int'(bus.vote_ready), 0);
    bus.enable = 1'b1;

    // Wrap across 1023/0 both ways, tie, then lock via UP/DOWN/NONE/UP
    window("up_wrap",   8, 0, 0, 1'b1, 10'd2,    1'b0);
    window("down_wrap", 0, 8, 0, 1'b1, 10'd1022, 1'b0);
    window("tie",       4, 4, 0, 1'b0, 10'd1022, 1'b0);
    window("up_lock",   8, 0, 0, 1'b1, 10'd2,    1'b1);

    // Reset during APPLY
    for (int i = 0; i < 8; i++) vote(1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rstapply_code", int'(bus.code), int'(INIT));
    check("rstapply_lock", int'(bus.lock), 0);
    check("rstapply_upd", int'(bus.code_update), 0);
    check("rstapply_ready", int'(bus.vote_ready), 0);
    @(negedge clk);
    rst = 1'b0;

    // Alternation after reset raises lock on the 4th decision
    window("alt1", 8, 0, 0, 1'b1, 10'd2,    1'b0);
    window("alt2", 0, 8, 0, 1'b1, 10'd1022, 1'b0);
    window("alt3", 8, 0, 0, 1'b1, 10'd2,    1'b0);
    window("alt4", 0, 8, 0, 1'b1, 10'd1022, 1'b1);
    window("alt5", 8, 0, 0, 1'b1, 10'd2,    1'b1);
    window("same", 8, 0, 0, 1'b1, 10'd6,    1'b0);
    window("mixed_down", 2, 5, 1, 1'b1, 10'd2, 1'b0);

    // Hold mid-window: partial votes discarded, code frozen
    for (int i = 0; i < 5; i++) vote(1'b1, 1'b0);
    @(negedge clk);
    bus.hold = 1'b1;
    @(negedge clk);
    check("hold_ready", int'(bus.vote_ready), 0);
    repeat (3) @(negedge clk);
    check("hold_code", int'(bus.code), 2);
    check("hold_upd", int'(bus.code_update), 0);
    bus.hold = 1'b0;
    window("post_hold", 0, 8, 0, 1'b1, 10'd1022, 1'b0);

    // Hold raised during APPLY abandons the update
    for (int i = 0; i < 8; i++) vote(1'b1, 1'b0);
    @(negedge clk);
    bus.hold = 1'b1;
    @(negedge clk);
    check("abandon_code", int'(bus.code), 1022);
    check("abandon_upd", int'(bus.code_update), 0);
    check("abandon_ready", int'(bus.vote_ready), 0);
    @(negedge clk);
    bus.hold = 1'b0;
    window("post_abandon", 8, 0, 0, 1'b1, 10'd2, 1'b0);

    // Disable drops vote_ready
    @(negedge clk);
    bus.enable = 1'b0;
    @(negedge clk);
    check("disable_ready", int'(bus.vote_ready), 0);
    bus.enable = 1'b1;

    // Long UP run from a fresh integrator
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mc    = INIT;
    integ = 0;
    for (int k = 0; k < 65; k++) begin
`ifdef PI_CTRL_FREQ_PATH_EN
      st = 4 + (integ >>> 6);
`else
      st = 4;
`endif
      mc = mc + 10'(st);
      window("freq_up", 8, 0, 0, 1'b1, mc, 1'b0);
      integ++;
    end

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pi_code_ctrl.md
# pi_code_ctrl

Digital phase controller for the CDR phase mixer. It collects early/late votes from the bang-bang phase detector and filters them over a fixed window. From each window decision it advances or retards a 10-bit phase code (`Code[9:8]` quadrant, `Code[7:0]` interpolation weight) that drives the mixer directly. It sits between the phase detector and the phase mixer, and can optionally include an integral (frequency-tracking) path.

## Interface
- `VOTE_LEN`, 8: accepted votes per decision window (2..255).
- `KP`, 4: proportional phase step in code LSBs (1..127).
- `INIT_CODE`, 10'd0: code loaded at reset.
- `FREQ_W`, 12: signed frequency-integrator width.
- `KI_SHIFT`, 6: arithmetic right shift applied to the integrator before it is added to the step.
- `CLK` in 1: single clock, rising edge.
- `RST` in 1: asynchronous, active-high reset.
- `Enable` in 1: loop enable.
- `Hold` in 1: freeze loop; code and integrator are held.
- `Vote_Valid` in 1: vote present this cycle.
- `Early` in 1: sampling clock is early, so the code increases.
- `Late` in 1: sampling clock is late, so the code decreases.
- `Vote_Ready` out 1: a vote is accepted when `Vote_Valid && Vote_Ready`.
- `Code` out 10: phase code to the mixer.
- `Code_Update` out 1: one-cycle pulse whenever `Code` changed on the preceding edge.
- `Lock` out 1: loop is dithering around the lock point.

## Operation
- Phase wheel:
  - `Code` is an unsigned index modulo 1024, with 256 steps per quadrant.
  - Weight 255 of quadrant q is adjacent to weight 0 of quadrant q+1.
  - 1023 wraps to 0, and 0 minus 1 wraps to 1023.
- States:
  - IDLE: `Enable`=0 or `Hold`=1. `Vote_Ready`=0; the vote sum and count are cleared.
  - ACCUM: `Vote_Ready`=1. Each accepted vote adds +1 (Early only), -1 (Late only) or 0 (both or neither) to a signed sum and increments a count.
  - APPLY: exactly one cycle. `Vote_Ready`=0; the step is computed, `Code` is written, then the state returns to ACCUM with sum and count cleared.
- Transitions:
  - IDLE→ACCUM when `Enable && !Hold`.
  - ACCUM→APPLY on the edge that accepts the `VOTE_LEN`-th vote.
  - Any state→IDLE when `Enable`=0 or `Hold`=1. This includes APPLY: the update is abandoned and `Code` is unchanged.
- Decision:
  - sum>0 is UP, sum<0 is DOWN, sum=0 is NONE.
  - NONE: `Code` is unchanged and there is no `Code_Update`, but the lock tracker still sees NONE.
- Step:
  - UP gives +KP and DOWN gives -KP.
  - With the frequency path compiled in, `(integ >>> KI_SHIFT)` is added for both UP and DOWN, using the integrator value before this decision's update.
  - The total step is clamped to -127..+127 and added to `Code` modulo 1024.
  - A total step of 0 produces no `Code_Update`.
- Integrator:
  - Signed, `FREQ_W` bits.
  - +1 on UP, -1 on DOWN, unchanged on NONE.
  - Saturates at the max/min values and never wraps.
- Lock:
  - Set after 4 consecutive decisions that alternate UP/DOWN or are NONE.
  - Cleared by two consecutive same-direction decisions, by IDLE, or by reset.

## Timing
- Reset values:
  - `Code`=INIT_CODE, `Code_Update`=0, `Vote_Ready`=0, `Lock`=0.
  - State IDLE; sum, count and integrator are 0.
- Reset is asynchronous and takes effect immediately, including during APPLY.
- Latency: the `VOTE_LEN`-th vote is accepted at edge n. The state is APPLY during cycle n..n+1. The new `Code` and `Code_Update`=1 are visible after edge n+1 and hold for one cycle.
- Votes offered during APPLY or IDLE are not accepted. The detector must hold or drop them.
- `Hold` or `Enable` changes take effect on the next edge; `Vote_Ready` drops in the cycle that follows.
- `Code` is glitch-free: it changes only on edges, and only from APPLY.

## Configuration
- `PI_CTRL_FREQ_PATH_EN` defined: the integrator and its step term are built; `FREQ_W` and `KI_SHIFT` are active.
- Not defined: no integrator exists; the step is exactly ±KP; `FREQ_W` and `KI_SHIFT` are ignored.

## Test plan
- Step up: `INIT_CODE`=0, 8 Early-only votes → `Code`=4 two cycles after the 8th accept, and a single `Code_Update` pulse.
- Wrap: from `Code`=1022, UP → `Code`=2 (quadrant 00). Then DOWN → 1022 (quadrant 11).
- Tie: 4 Early and 4 Late votes → `Code` unchanged, no `Code_Update`, `Vote_Ready` low for exactly one cycle.
- Hold: assert `Hold` after 5 votes and release it → the next decision needs 8 fresh votes, and the code is unchanged during the hold.
- Frequency path (macro defined): 64 consecutive UP decisions → steps of 4 until integ=64, then the 65th decision steps 5. With the macro undefined, every step is 4.
- Reset asserted during APPLY → `Code`=INIT_CODE immediately; `Lock`, `Code_Update` and `Vote_Ready` are 0; alternating UP/DOWN ×4 afterwards raises `Lock`.
